// File: rtl/hermes_pkt_sink_if.sv
// Hermes local-port bundle: DMNI flit input with credit, plus the payload output stream.
interface hermes_pkt_sink_if #(
    parameter int unsigned FLIT_W = 32
);
    logic              noc_rx_i;
    logic              noc_eop_i;
    logic [FLIT_W-1:0] noc_data_i;
    logic              noc_credit_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [FLIT_W-1:0] out_data_o;
    logic              out_eop_o;

    // Producer of flits and consumer of the payload stream
    modport master (
        output noc_rx_i, noc_eop_i, noc_data_i, out_ready_i,
        input  noc_credit_o, out_valid_o, out_data_o, out_eop_o
    );

    // The packet sink itself
    modport slave (
        input  noc_rx_i, noc_eop_i, noc_data_i, out_ready_i,
        output noc_credit_o, out_valid_o, out_data_o, out_eop_o
    );
endinterface

// File: rtl/hermes_pkt_sink.sv
// Credit-based Hermes packet receiver: checks framing/destination, buffers payload, streams it out.
module hermes_pkt_sink #(
    parameter int unsigned HERMES_FLIT_SIZE = 32,
    parameter int unsigned BUFFER_SIZE      = 16,
    parameter logic [15:0] ADDRESS          = 16'h0000
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    hermes_pkt_sink_if.slave    bus,
    output logic [31:0]         pkt_size_o,
    output logic                pkt_done_o,
    output logic                err_addr_o,
    output logic                err_len_o,
    output logic [31:0]         pkt_count_o
);
    localparam int unsigned W       = HERMES_FLIT_SIZE;
    localparam int unsigned ENTRY_W = W + 1;
    localparam int unsigned PTR_W   = $clog2(BUFFER_SIZE);
    localparam int unsigned CNT_W   = PTR_W + 1;

    typedef enum logic [1:0] {S_HEADER, S_SIZE, S_PAYLOAD, S_DROP} state_t;

    state_t               state_q, state_d;
    logic [31:0]          remaining_q;
    logic [ENTRY_W-1:0]   mem [BUFFER_SIZE];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [ENTRY_W-1:0]   head_q, head_d, push_word;
    logic                 credit_q, valid_q;
    logic                 xfer, pop, eop, hdr_match, rem_one, size_zero;
    logic                 push, tag_eop, done, err_addr, err_len, size_ld;

    assign xfer      = bus.noc_rx_i && credit_q;
    assign pop       = valid_q && bus.out_ready_i;
    assign eop       = bus.noc_eop_i;
    assign hdr_match = (bus.noc_data_i[15:0] == ADDRESS);
    assign rem_one   = (remaining_q == 32'd1);
    assign size_zero = (bus.noc_data_i == '0);
    assign push_word = {tag_eop, bus.noc_data_i};

    assign bus.noc_credit_o = credit_q;
    assign bus.out_valid_o  = valid_q;
    assign bus.out_data_o   = head_q[W-1:0];
    assign bus.out_eop_o    = head_q[W];

    // Parser state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_HEADER;
        else         state_q <= state_d;
    end

    // Parser next state, advanced only on an accepted flit
    always_comb begin
        state_d = state_q;
        if (xfer) begin
            case (state_q)
                S_HEADER:  state_d = eop ? S_HEADER : (hdr_match ? S_SIZE : S_DROP);
                S_SIZE: begin
                    if (eop)            state_d = S_HEADER;
                    else if (size_zero) state_d = S_DROP;
                    else                state_d = S_PAYLOAD;
                end
                S_PAYLOAD: begin
                    if (eop)          state_d = S_HEADER;
                    else if (rem_one) state_d = S_DROP;
                    else              state_d = S_PAYLOAD;
                end
                S_DROP:    state_d = eop ? S_HEADER : S_DROP;
                default:   state_d = S_HEADER;
            endcase
        end
    end

    // Parser actions: FIFO push, eop tagging and status events
    always_comb begin
        push     = 1'b0;
        tag_eop  = 1'b0;
        done     = 1'b0;
        err_addr = 1'b0;
        err_len  = 1'b0;
        size_ld  = 1'b0;
        if (xfer) begin
            case (state_q)
                S_HEADER: begin
                    if (eop)             err_len  = 1'b1;
                    else if (!hdr_match) err_addr = 1'b1;
                end
                S_SIZE: begin
                    size_ld = 1'b1;
                    if (size_zero) begin
                        if (eop) done    = 1'b1;
                        else     err_len = 1'b1;
                    end else if (eop) begin
                        err_len = 1'b1;
                    end
                end
                S_PAYLOAD: begin
                    push = 1'b1;
                    if (rem_one) begin
                        tag_eop = 1'b1;
                        if (eop) done    = 1'b1;
                        else     err_len = 1'b1;
                    end else if (eop) begin
                        tag_eop = 1'b1;
                        err_len = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // FIFO bookkeeping; the head word is pre-computed so the output stage is a register
    always_comb begin
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        head_d   = (push && (rd_ptr_d == wr_ptr_q)) ? push_word : mem[rd_ptr_d];
    end

    // Payload storage (no reset needed, guarded by the occupancy count)
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= push_word;
    end

    // FIFO pointers, occupancy, output stage and credit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            credit_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= (count_d != '0);
            if (count_d != '0) head_q <= head_d;
            // Dropped flits never enter the FIFO, so credit stays up while discarding
            credit_q <= (state_d == S_DROP) || (count_d != CNT_W'(BUFFER_SIZE));
        end
    end

    // Remaining payload counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      remaining_q <= '0;
        else if (size_ld) remaining_q <= 32'(bus.noc_data_i);
        else if (push)    remaining_q <= remaining_q - 32'd1;
    end

    // Status pulses, size capture and packet counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pkt_done_o  <= 1'b0;
            err_addr_o  <= 1'b0;
            err_len_o   <= 1'b0;
            pkt_size_o  <= '0;
            pkt_count_o <= '0;
        end else begin
            pkt_done_o <= done;
            err_addr_o <= err_addr;
            err_len_o  <= err_len;
            if (size_ld) pkt_size_o  <= 32'(bus.noc_data_i);
            if (done)    pkt_count_o <= pkt_count_o + 32'd1;
        end
    end
endmodule

// File: tb/tb_hermes_pkt_sink.sv
// Self-checking bench for hermes_pkt_sink with a packet-level reference model.
module tb_hermes_pkt_sink;
    localparam logic [15:0] OWN = 16'h0101;
    localparam int unsigned BUF = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pkt_size, pkt_count;
    logic        pkt_done, err_addr, err_len;

    hermes_pkt_sink_if #(.FLIT_W(32)) bus ();

    hermes_pkt_sink #(
        .HERMES_FLIT_SIZE(32),
        .BUFFER_SIZE(BUF),
        .ADDRESS(OWN)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .bus(bus),
        .pkt_size_o(pkt_size),
        .pkt_done_o(pkt_done),
        .err_addr_o(err_addr),
        .err_len_o(err_len),
        .pkt_count_o(pkt_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0, n_pass = 0;
    int          seen_done = 0, seen_err_addr = 0, seen_err_len = 0;
    int          exp_done = 0, exp_err_addr = 0, exp_err_len = 0;
    logic [31:0] exp_count = '0, exp_size = '0;
    logic [32:0] exp_q[$];
    logic [32:0] pkt_q[$];
    int          ready_mode = 0;
    bit          hold_pending = 1'b0;
    logic [32:0] hold_word;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Output monitor: pulse counting, scoreboard pops and stall stability
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            if (pkt_done) seen_done++;
            if (err_addr) seen_err_addr++;
            if (err_len)  seen_err_len++;
            if (hold_pending) begin
                check("hold_valid", 64'(bus.out_valid_o), 64'd1);
                check("hold_word", 64'({bus.out_eop_o, bus.out_data_o}), 64'(hold_word));
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
                check("pop_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0)
                    check("out_word", 64'({bus.out_eop_o, bus.out_data_o}), 64'(exp_q.pop_front()));
            end
            hold_pending = bus.out_valid_o && !bus.out_ready_i;
            hold_word    = {bus.out_eop_o, bus.out_data_o};
        end
    end

    // Consumer ready: 0 = stall, 1 = always ready, else random
    initial begin
        bus.out_ready_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       bus.out_ready_i = 1'b0;
                1:       bus.out_ready_i = 1'b1;
                default: bus.out_ready_i = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // One flit, held until the sink grants credit
    task automatic send_flit(input logic [32:0] w);
        int budget = 0;
        bit ok;
        bus.noc_rx_i   = 1'b1;
        bus.noc_eop_i  = w[32];
        bus.noc_data_i = w[31:0];
        forever begin
            @(negedge clk); ok = bus.noc_credit_o;
            @(posedge clk); #1;
            if (ok) break;
            budget++;
            if (budget > 500) begin
                check("credit_timeout", 64'(ok), 64'd1);
                break;
            end
        end
        bus.noc_rx_i  = 1'b0;
        bus.noc_eop_i = 1'b0;
    endtask

    // t = total flits including header (and size flit when t >= 2); eop on the last one
    task automatic build_pkt(input logic [15:0] addr, input int n, input int t);
        logic [15:0] hi;
        pkt_q.delete();
        hi = 16'($urandom);
        pkt_q.push_back({(t == 1), hi, addr});
        if (t >= 2) pkt_q.push_back({(t == 2), 32'(n)});
        for (int i = 0; i < t - 2; i++) pkt_q.push_back({(i == t - 3), 32'($urandom)});
    endtask

    // Packet-level expectations derived from address, declared size and actual length
    task automatic model_pkt(input logic [15:0] addr, input int n, input int t);
        int p, k;
        if (t == 1) begin
            exp_err_len++;
        end else if (addr != OWN) begin
            exp_err_addr++;
        end else begin
            exp_size = 32'(n);
            p = t - 2;
            if (n == 0) begin
                if (p == 0) begin exp_done++; exp_count++; end
                else        exp_err_len++;
            end else if (p == 0) begin
                exp_err_len++;
            end else begin
                k = (n < p) ? n : p;
                for (int i = 0; i < k; i++) exp_q.push_back({(i == k - 1), pkt_q[2 + i][31:0]});
                if (p == n) begin exp_done++; exp_count++; end
                else        exp_err_len++;
            end
        end
    endtask

    task automatic send_pkt(input int gap_max);
        foreach (pkt_q[i]) begin
            send_flit(pkt_q[i]);
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
        end
    endtask

    task automatic drain_and_check();
        int b = 0;
        while ((exp_q.size() != 0 || bus.out_valid_o) && b < 300) begin
            tick();
            b++;
        end
        repeat (3) tick();
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        check("pkt_done_count", 64'(seen_done), 64'(exp_done));
        check("err_addr_count", 64'(seen_err_addr), 64'(exp_err_addr));
        check("err_len_count", 64'(seen_err_len), 64'(exp_err_len));
        check("pkt_count", 64'(pkt_count), 64'(exp_count));
        check("pkt_size", 64'(pkt_size), 64'(exp_size));
    endtask

    task automatic run_pkt(input logic [15:0] addr, input int n, input int t, input int gap_max);
        build_pkt(addr, n, t);
        model_pkt(addr, n, t);
        send_pkt(gap_max);
        drain_and_check();
    endtask

    initial begin
        bus.noc_rx_i   = 1'b0;
        bus.noc_eop_i  = 1'b0;
        bus.noc_data_i = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_credit", 64'(bus.noc_credit_o), 64'd0);
        check("rst_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst_count", 64'(pkt_count), 64'd0);
        check("rst_size", 64'(pkt_size), 64'd0);
        check("rst_pulses", 64'({pkt_done, err_addr, err_len}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("credit_after_rst", 64'(bus.noc_credit_o), 64'd1);
        tick();
        ready_mode = 1;
        tick();

        // Well-formed packet, header mismatch, length errors, zero size
        run_pkt(OWN, 3, 5, 0);
        run_pkt(16'h0202, 2, 4, 0);
        check("credit_after_drop", 64'(bus.noc_credit_o), 64'd1);
        run_pkt(OWN, 2, 4, 0);
        run_pkt(OWN, 4, 4, 0);
        run_pkt(OWN, 1, 5, 0);
        run_pkt(OWN, 0, 2, 0);
        run_pkt(OWN, 0, 1, 0);
        run_pkt(OWN, 0, 4, 0);
        run_pkt(OWN, 5, 2, 0);

        // Backpressure: FIFO fills, credit drops, then drains in order
        ready_mode = 0;
        repeat (2) tick();
        build_pkt(OWN, 6, 8);
        model_pkt(OWN, 6, 8);
        for (int i = 0; i < 6; i++) send_flit(pkt_q[i]);
        repeat (3) begin
            @(negedge clk);
            check("bp_credit_low", 64'(bus.noc_credit_o), 64'd0);
            check("bp_valid", 64'(bus.out_valid_o), 64'd1);
            check("bp_head", 64'({bus.out_eop_o, bus.out_data_o}), 64'(pkt_q[2]));
            tick();
        end
        ready_mode = 1;
        for (int i = 6; i < 8; i++) send_flit(pkt_q[i]);
        drain_and_check();

        // Randomized traffic with random consumer stalls and flit gaps
        ready_mode = 2;
        for (int r = 0; r < 40; r++) begin
            logic [15:0] a;
            int n, p, t;
            a = ($urandom_range(0, 4) == 0) ? 16'h0202 : OWN;
            if ($urandom_range(0, 9) == 0) begin
                t = 1; n = 0;
            end else begin
                p = $urandom_range(0, 6);
                n = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 6) : p;
                t = p + 2;
            end
            run_pkt(a, n, t, 2);
        end

        // Reset in the middle of a payload
        ready_mode = 0;
        repeat (2) tick();
        build_pkt(OWN, 5, 7);
        for (int i = 0; i < 4; i++) send_flit(pkt_q[i]);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_credit", 64'(bus.noc_credit_o), 64'd0);
        check("midrst_valid", 64'(bus.out_valid_o), 64'd0);
        check("midrst_count", 64'(pkt_count), 64'd0);
        exp_q.delete();
        exp_count = '0;
        exp_size  = '0;
        tick();
        tick();
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("credit_after_midrst", 64'(bus.noc_credit_o), 64'd1);
        tick();
        ready_mode = 1;
        tick();
        run_pkt(OWN, 3, 5, 0);
        run_pkt(OWN, 2, 4, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/hermes_pkt_sink.md
Name: hermes_pkt_sink

Overview:
Credit-based Hermes local-port receiver. It sits at the router end of the DMNI Hermes output and consumes the packets the DMNI injects (header flit, size flit, payload flits, eop on the last flit). It validates framing and the destination, buffers accepted payload flits in an internal FIFO, and presents them on a valid/ready stream with packet delimiters. It is also used as a scoreboard-grade sink in PE-level benches.

Parameters:
HERMES_FLIT_SIZE, 32, flit width in bits (minimum 16).
BUFFER_SIZE, 16, payload FIFO depth in flits (power of two, ≥2).
ADDRESS, 16'h0000, own XY address; header flit [15:0] must match.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  asynchronous active-low reset.
noc_rx_i  in  1  flit valid from the DMNI (noc_tx_o).
noc_eop_i  in  1  last flit of the packet.
noc_data_i  in  HERMES_FLIT_SIZE  flit.
noc_credit_o  out  1  space available; a transfer occurs when noc_rx_i && noc_credit_o.
out_valid_o  out  1  payload flit valid.
out_ready_i  in  1  consumer accepts; a pop occurs when valid && ready.
out_data_o  out  HERMES_FLIT_SIZE  payload flit.
out_eop_o  out  1  last payload flit of the packet.
pkt_size_o  out  32  size field of the last accepted header (zero-extended).
pkt_done_o  out  1  one-cycle pulse when a well-formed packet has been fully received.
err_addr_o  out  1  one-cycle pulse when a packet is dropped for header mismatch.
err_len_o  out  1  one-cycle pulse on a size/eop disagreement.
pkt_count_o  out  32  well-formed packets received (wraps).

Behaviour:
- Reset: FSM = HEADER, FIFO empty, noc_credit_o=0 during reset and 1 from the first cycle after it. All other outputs reset to 0.
- Interface: one clock, asynchronous active-low reset rst_ni; the clock port is clk_i.
- noc_credit_o = !fifo_full, driven from registered occupancy with no combinational path from noc_rx_i. Header and size flits are always accepted while credit is high.
- FSM, advanced only on a transfer:
  - HEADER:
    - data[15:0]==ADDRESS and !eop → SIZE.
    - Mismatch and !eop → DROP, with err_addr_o pulsed.
    - Header with eop → err_len_o pulsed, stay in HEADER.
  - SIZE: latch remaining = data (zero-extended to 32 bits), pkt_size_o = same.
    - size 0 with eop → pkt_done, HEADER.
    - size 0 without eop → err_len, DROP.
    - size ≠ 0 with eop → err_len, HEADER.
    - Otherwise → PAYLOAD.
  - PAYLOAD: push {eop_tag, data} into the FIFO and decrement remaining.
    - remaining==1 and eop → tag eop, pkt_done, pkt_count++, HEADER.
    - remaining==1 and !eop → tag eop, err_len, DROP.
    - remaining>1 and eop (early) → tag eop, err_len, HEADER.
  - DROP: discard flits with credit held high, regardless of FIFO state. Return to HEADER on the eop flit.
- Status pulses (pkt_done_o, err_addr_o, err_len_o) are registered: asserted the cycle after the triggering transfer, for exactly one cycle.
- Latency: out_valid_o rises 1 cycle after a payload flit transfer into an empty FIFO (registered FIFO output).
- FIFO:
  - Simultaneous push and pop when full: the pop frees space, but credit stays low that cycle (registered), so no push arrives when full.
  - A push is never dropped while credit was high.
  - Read/write pointers wrap modulo BUFFER_SIZE. Occupancy counter is $clog2(BUFFER_SIZE)+1 bits.
- out_data_o and out_eop_o hold stable while out_valid_o && !out_ready_i.
- Reset mid-packet discards all state and the FIFO contents. The next transfer is parsed as a header.
- pkt_count_o wraps from 32'hFFFF_FFFF to 0.

Test Plan:
- ADDRESS=16'h0101: send {0101, 3, A, B, C(eop)} with ready=1 → out flits A, B, C; out_eop_o only on C; pkt_done pulse; pkt_count=1; pkt_size_o=3.
- Header 16'h0202 with 4 flits → no output, err_addr pulse, credit stays 1, the next valid packet is received normally.
- {0101, 4, A, B(eop)} → A, B(out_eop) output, err_len pulse, pkt_count unchanged; {0101, 1, A, B, C(eop)} → A(out_eop) output, err_len, B and C dropped.
- BUFFER_SIZE=4, ready=0, 6-payload packet → credit drops after the 4th payload flit; releasing ready delivers all 6 in order with no loss.
- Zero-size packet {0101, 0(eop)} → pkt_done, no FIFO output; pkt_count increments.
- Assert rst_ni low mid-payload → credit=0 and FIFO empty; after release, a fresh packet is parsed correctly.
